// File: rtl/nubus_sram_ctrl.sv
// nubus_sram_ctrl
// ----------------
// Slave-side memory controller that sits behind the NuBus slave port. It takes
// one mem_valid request, issues exactly one single-port synchronous SRAM
// access with byte-lane write enables, optionally waits WAIT_STATES extra
// cycles, and then returns a one-cycle mem_ready pulse with the read data.
//
// All flops update on the falling edge of nub_clkn (the NuBus sampling edge)
// and clear asynchronously while nub_resetn is low.
//
// Parameters
//   ADDR_W       SRAM word-address width (depth = 2**ADDR_W x 32 bits)
//   WAIT_STATES  extra cycles between the SRAM access and completion, 0..15
//
// Ports
//   nub_clkn, nub_resetn          bus clock (falling edge active), async low reset
//   mem_valid/addr/wstrb/wdata    request from the slave port (wstrb == 0 is a read)
//   mem_myslot, mem_myexp         request targets this card's slot / expansion space
//   mem_ready, mem_rdata          completion pulse and read data (held until next read)
//   mem_write                     debug: high during the cycle an SRAM write is issued
//   sram_cs/we/addr/wdata         SRAM control, registered
//   sram_rdata                    SRAM read data, valid one edge after sram_cs
//
// Build option
//   NUBUS_SRAM_REGOUT_EN  when defined, an extra output register stage follows
//                         CAPTURE, so mem_ready/mem_rdata arrive one cycle later
//                         and sram_rdata passes through two flops on its way out.

module nubus_sram_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic              nub_clkn,
    input  logic              nub_resetn,
    input  logic              mem_valid,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_myslot,
    input  logic              mem_myexp,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              mem_write,
    output logic              sram_cs,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE,
        ST_HOLD
    } state_t;

    // The wait counter counts WAIT_STATES cycles in ST_WAIT, so it is loaded
    // with one less; the guard keeps the constant legal when WAIT_STATES is 0.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          strb_q, strb_d;
    logic                cs_q, cs_d;
    logic [3:0]          we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
`ifdef NUBUS_SRAM_REGOUT_EN
    logic [31:0]         rdataCap_q, rdataCap_d;
`endif

    logic select;
    logic isRead;

    // Word address only: upper bits alias and the byte offset is resolved upstream.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign select = mem_valid & (mem_myslot | mem_myexp);
    assign isRead = (strb_q == 4'b0000);

    // Next-state and output-register logic. The SRAM control and the
    // completion pulse are computed one state early so that they leave the
    // design straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        strb_d  = strb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cs_d    = 1'b0;
        we_d    = 4'b0000;
        ready_d = 1'b0;
`ifdef NUBUS_SRAM_REGOUT_EN
        rdataCap_d = rdataCap_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (select) begin
                    addr_d  = mem_addr[ADDR_W+1:2];
                    strb_d  = mem_wstrb;
                    wdata_d = mem_wdata;
                    cs_d    = 1'b1;
                    we_d    = mem_wstrb;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (WAIT_STATES > 0) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_CAPTURE: begin
`ifdef NUBUS_SRAM_REGOUT_EN
                rdataCap_d = sram_rdata;
`else
                // A write completes without disturbing the last read data.
                ready_d = 1'b1;
                if (isRead) begin
                    rdata_d = sram_rdata;
                end
`endif
                state_d = ST_DONE;
            end

            ST_DONE: begin
`ifdef NUBUS_SRAM_REGOUT_EN
                ready_d = 1'b1;
                if (isRead) begin
                    rdata_d = rdataCap_q;
                end
`endif
                state_d = ST_HOLD;
            end

            ST_HOLD: begin
                // A request still asserted is the one just served; wait for
                // it to drop so it cannot trigger a second SRAM access.
                if (!mem_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            strb_q  <= 4'b0000;
            cs_q    <= 1'b0;
            we_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef NUBUS_SRAM_REGOUT_EN
    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            rdataCap_q <= 32'd0;
        end else begin
            rdataCap_q <= rdataCap_d;
        end
    end
`endif

    assign mem_ready  = ready_q;
    assign mem_rdata  = rdata_q;
    assign sram_cs    = cs_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign mem_write  = cs_q & (|we_q);

endmodule

// File: tb/tb_nubus_sram_ctrl.sv
// Testbench for nubus_sram_ctrl. Two instances share one request stream:
// inst0 with WAIT_STATES=0 and inst1 with WAIT_STATES=3. Each has its own
// behavioural SRAM. Expected completions (read data and the edge at which
// mem_ready must appear) are queued when a request is driven and popped when
// the instance raises mem_ready.

module tb_nubus_sram_ctrl;

`ifdef NUBUS_SRAM_REGOUT_EN
    localparam int REG_EXTRA = 1;
`else
    localparam int REG_EXTRA = 0;
`endif
    localparam int LAT [2] = '{2 + REG_EXTRA, 5 + REG_EXTRA};

    typedef struct {
        logic [31:0] rdata;
        int          readyEdge;
    } exp_t;

    logic        nub_clkn;
    logic        nub_resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_myslot;
    logic        mem_myexp;

    logic        memReady  [2];
    logic [31:0] memRdata  [2];
    logic        memWrite  [2];
    logic        sramCs    [2];
    logic [3:0]  sramWe    [2];
    logic [11:0] sramAddr  [2];
    logic [31:0] sramWdata [2];
    logic [31:0] sramRdata [2] = '{default: '0};

    logic [31:0] sramMem [2][4096] = '{default: '{default: '0}};
    logic [31:0] refMem  [4096]    = '{default: '0};
    logic [31:0] lastRead = 32'd0;

    exp_t expQ [2][$];

    int          edgeCnt = 0;
    int          csCnt   [2] = '{0, 0};
    int          wrCnt   [2] = '{0, 0};
    int          rdyCnt  [2] = '{0, 0};
    logic [11:0] lastAddr[2] = '{default: '0};
    logic [3:0]  lastWe  [2] = '{default: '0};

    int checks = 0;
    int errors = 0;

    nubus_sram_ctrl #(.ADDR_W(12), .WAIT_STATES(0)) dut0 (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_myslot (mem_myslot),
        .mem_myexp  (mem_myexp),
        .mem_ready  (memReady[0]),
        .mem_rdata  (memRdata[0]),
        .mem_write  (memWrite[0]),
        .sram_cs    (sramCs[0]),
        .sram_we    (sramWe[0]),
        .sram_addr  (sramAddr[0]),
        .sram_wdata (sramWdata[0]),
        .sram_rdata (sramRdata[0])
    );

    nubus_sram_ctrl #(.ADDR_W(12), .WAIT_STATES(3)) dut1 (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_myslot (mem_myslot),
        .mem_myexp  (mem_myexp),
        .mem_ready  (memReady[1]),
        .mem_rdata  (memRdata[1]),
        .mem_write  (memWrite[1]),
        .sram_cs    (sramCs[1]),
        .sram_we    (sramWe[1]),
        .sram_addr  (sramAddr[1]),
        .sram_wdata (sramWdata[1]),
        .sram_rdata (sramRdata[1])
    );

    initial begin
        nub_clkn = 1'b1;
        forever #5 nub_clkn = ~nub_clkn;
    end

    always @(negedge nub_clkn) edgeCnt++;

    // Synchronous SRAMs: sample on the falling edge, read data appears after it.
    always @(negedge nub_clkn) begin
        for (int i = 0; i < 2; i++) begin
            if (sramCs[i] === 1'b1) begin
                for (int b = 0; b < 4; b++) begin
                    if (sramWe[i][b]) begin
                        sramMem[i][sramAddr[i]][8*b +: 8] <= sramWdata[i][8*b +: 8];
                    end
                end
                sramRdata[i] <= sramMem[i][sramAddr[i]];
            end
        end
    end

    // Pulse counters, sampled mid-cycle on the rising edge.
    always @(posedge nub_clkn) begin
        for (int i = 0; i < 2; i++) begin
            if (sramCs[i] === 1'b1) begin
                csCnt[i]++;
                lastAddr[i] = sramAddr[i];
                lastWe[i]   = sramWe[i];
            end
            if (memWrite[i] === 1'b1) wrCnt[i]++;
            if (memReady[i] === 1'b1) rdyCnt[i]++;
        end
    end

    task automatic checkInt(input string tag, input int inst, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s inst%0d: observed %0d expected %0d", tag, inst, obs, expv);
        end
    endtask

    task automatic check32(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s inst%0d: observed %h expected %h", tag, inst, obs, expv);
        end
    endtask

    // Advance to the next rising edge and retire any completion seen there.
    task automatic serviceCycle();
        exp_t e;
        @(posedge nub_clkn);
        for (int i = 0; i < 2; i++) begin
            if (memReady[i] === 1'b1) begin
                checks++;
                assert (expQ[i].size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_ready inst%0d: observed ready 1 expected 0 at edge %0d", i, edgeCnt);
                end
                if (expQ[i].size() > 0) begin
                    e = expQ[i].pop_front();
                    checkInt("ready_edge", i, edgeCnt, e.readyEdge);
                    check32("rdata", i, memRdata[i], e.rdata);
                end
            end
        end
    endtask

    // Drive one request, predict its outcome, wait for both instances, then
    // hold for extraHold cycles, release mem_valid and check pulse counts.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] strb,
                                 input logic [31:0] wdata, input logic slot,
                                 input logic expn, input int extraHold);
        int          csBase [2];
        int          wrBase [2];
        int          rdyBase[2];
        logic [11:0] idx;
        logic [31:0] expRd;
        exp_t        e;
        int          n;

        idx = addr[13:2];
        for (int i = 0; i < 2; i++) begin
            csBase[i]  = csCnt[i];
            wrBase[i]  = wrCnt[i];
            rdyBase[i] = rdyCnt[i];
        end

        mem_valid  = 1'b1;
        mem_addr   = addr;
        mem_wstrb  = strb;
        mem_wdata  = wdata;
        mem_myslot = slot;
        mem_myexp  = expn;
        n = edgeCnt + 1;

        if (strb == 4'b0000) begin
            expRd    = refMem[idx];
            lastRead = expRd;
        end else begin
            expRd = lastRead;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) refMem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end

        for (int i = 0; i < 2; i++) begin
            e.rdata     = expRd;
            e.readyEdge = n + LAT[i];
            expQ[i].push_back(e);
        end

        for (int c = 0; c < 40 && (expQ[0].size() + expQ[1].size()) != 0; c++) begin
            serviceCycle();
        end
        for (int i = 0; i < 2; i++) begin
            checkInt("completion_pending", i, expQ[i].size(), 0);
            expQ[i].delete();
        end

        repeat (extraHold) serviceCycle();
        mem_valid  = 1'b0;
        mem_myslot = 1'b0;
        mem_myexp  = 1'b0;
        repeat (3) serviceCycle();

        for (int i = 0; i < 2; i++) begin
            checkInt("cs_pulses", i, csCnt[i] - csBase[i], 1);
            checkInt("ready_pulses", i, rdyCnt[i] - rdyBase[i], 1);
            checkInt("write_pulses", i, wrCnt[i] - wrBase[i], (strb != 4'b0000) ? 1 : 0);
            check32("sram_addr", i, {20'd0, lastAddr[i]}, {20'd0, idx});
            check32("sram_we", i, {28'd0, lastWe[i]}, {28'd0, strb});
        end
    endtask

    // Check that nothing happened across a window of cycles.
    task automatic checkOutput(input string tag, input int csBase0, input int csBase1,
                               input int rdyBase0, input int rdyBase1);
        checkInt({tag, "_cs"}, 0, csCnt[0] - csBase0, 0);
        checkInt({tag, "_cs"}, 1, csCnt[1] - csBase1, 0);
        checkInt({tag, "_ready"}, 0, rdyCnt[0] - rdyBase0, 0);
        checkInt({tag, "_ready"}, 1, rdyCnt[1] - rdyBase1, 0);
    endtask

    initial begin
        int cs0, cs1, rd0, rd1;

        nub_resetn = 1'b0;
        mem_valid  = 1'b1;
        mem_addr   = 32'hF000_0000;
        mem_wstrb  = 4'b0000;
        mem_wdata  = 32'd0;
        mem_myslot = 1'b1;
        mem_myexp  = 1'b0;
        $display("[TB] reset held with mem_valid asserted");

        repeat (4) serviceCycle();
        for (int i = 0; i < 2; i++) begin
            checkInt("reset_ready", i, int'(memReady[i]), 0);
            checkInt("reset_cs", i, int'(sramCs[i]), 0);
            checkInt("reset_write", i, int'(memWrite[i]), 0);
            check32("reset_rdata", i, memRdata[i], 32'd0);
        end
        checkOutput("reset_window", 0, 0, 0, 0);

        // Released with the request still up: IDLE samples it on the first edge.
        nub_resetn = 1'b1;
        applyStimulus(32'hF000_0000, 4'b0000, 32'd0, 1'b1, 1'b0, 0);

        $display("[TB] word write and readback");
        applyStimulus(32'hF000_0000, 4'b1111, 32'h8765_4321, 1'b1, 1'b0, 0);
        applyStimulus(32'hF000_0000, 4'b0000, 32'd0, 1'b1, 1'b0, 0);

        $display("[TB] byte lane write, readback and alias");
        applyStimulus(32'hF000_0010, 4'b0010, 32'h8765_4321, 1'b1, 1'b0, 0);
        applyStimulus(32'hF000_0010, 4'b0000, 32'd0, 1'b1, 1'b0, 0);
        applyStimulus(32'hF000_4013, 4'b0000, 32'd0, 1'b1, 1'b0, 0);

        $display("[TB] held request then second access");
        applyStimulus(32'hF000_0000, 4'b0000, 32'd0, 1'b1, 1'b0, 10);
        applyStimulus(32'hF000_0010, 4'b0000, 32'd0, 1'b1, 1'b0, 0);

        $display("[TB] request not selected");
        cs0 = csCnt[0];
        cs1 = csCnt[1];
        rd0 = rdyCnt[0];
        rd1 = rdyCnt[1];
        mem_valid  = 1'b1;
        mem_addr   = 32'hF000_0000;
        mem_wstrb  = 4'b1111;
        mem_wdata  = 32'hDEAD_BEEF;
        mem_myslot = 1'b0;
        mem_myexp  = 1'b0;
        repeat (8) serviceCycle();
        checkOutput("unselected", cs0, cs1, rd0, rd1);

        $display("[TB] expansion-space access and mixed lanes");
        applyStimulus(32'hF000_0000, 4'b1001, 32'hAABB_CCDD, 1'b0, 1'b1, 0);
        applyStimulus(32'hF000_0000, 4'b0000, 32'd0, 1'b0, 1'b1, 0);
        applyStimulus(32'hFFFF_FFFC, 4'b1111, 32'h1234_5678, 1'b1, 1'b0, 0);
        applyStimulus(32'h0000_3FFC, 4'b0000, 32'd0, 1'b1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nubus_sram_ctrl.md
# nubus_sram_ctrl

Slave-side memory controller sitting directly downstream of the `nubus` slave port. It consumes the `mem_valid`/`mem_addr`/`mem_wstrb`/`mem_wdata` request interface and drives a single-port synchronous SRAM with byte-lane write enables. It returns a one-cycle `mem_ready` pulse and read data to the slave, and inserts a configurable number of wait states.

## Interface
- `ADDR_W`, 12, SRAM word-address width (SRAM depth = 2^ADDR_W words of 32 bits)
- `WAIT_STATES`, 0, extra cycles between SRAM access and completion, range 0..15
- `nub_clkn`  in  1  bus clock; all flops update on the falling edge of `nub_clkn` (the NuBus sampling edge)
- `nub_resetn`  in  1  asynchronous, active-low reset
- `mem_valid`  in  1  request from slave port
- `mem_addr`  in  32  byte address
- `mem_wstrb`  in  4  byte-lane write strobes; 0 = read
- `mem_wdata`  in  32  write data
- `mem_myslot`  in  1  request targets this card's slot space
- `mem_myexp`  in  1  request targets this card's expansion space
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1
- `mem_write`  out  1  debug: high for the cycle the SRAM write is issued
- `sram_cs`  out  1  SRAM chip select
- `sram_we`  out  4  SRAM byte write enables
- `sram_addr`  out  ADDR_W  SRAM word address
- `sram_wdata`  out  32  SRAM write data
- `sram_rdata`  in  32  SRAM read data, valid one edge after `sram_cs`

## Operation
- Select condition: `mem_valid & (mem_myslot | mem_myexp)`. If neither `mem_myslot` nor `mem_myexp` is set, the request is ignored.
- FSM states: IDLE, ACCESS, WAIT, CAPTURE, DONE, HOLD.
  - IDLE: if selected, latch `mem_addr[ADDR_W+1:2]`, `mem_wstrb` and `mem_wdata`, then go to ACCESS.
  - ACCESS: `sram_cs`=1 and `sram_we`=latched strobes for exactly one cycle. Go to WAIT if `WAIT_STATES`>0, otherwise to CAPTURE.
  - WAIT: 4-bit down-counter loaded with `WAIT_STATES`-1. Go to CAPTURE when it reaches 0.
  - CAPTURE: register `sram_rdata` into `mem_rdata` on reads only; a write leaves `mem_rdata` unchanged. Go to DONE.
  - DONE: `mem_ready`=1 for one cycle, then go to HOLD.
  - HOLD: stay until `mem_valid` is sampled 0, then go to IDLE. This guarantees exactly one SRAM access per request.
- Address bits `mem_addr[31:ADDR_W+2]` and `[1:0]` are ignored, so addresses alias modulo 2^ADDR_W words.
- Reads return the full 32-bit word. Lane selection is done upstream.
- `mem_valid` dropping after acceptance does not abort the access: the SRAM access and the `mem_ready` pulse still occur, and HOLD exits on the next edge.
- `mem_write` = `sram_cs & |sram_we`.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `mem_write`=0, `sram_cs`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0, FSM=IDLE, counter=0.
- Request sampled at edge N:
  - `sram_cs` is high from edge N to edge N+1.
  - `mem_ready` is high from edge N+2+`WAIT_STATES` for one cycle.
  - `mem_rdata` changes at the same edge and is held until the next read completes.
- Minimum spacing between two accepted requests: `mem_valid` must be low for at least one sampling edge after `mem_ready`.
- Reset asserted mid-operation: all outputs clear immediately and the FSM returns to IDLE. A write whose `sram_cs` is cut by reset is not guaranteed to land. SRAM contents are not cleared.
- `mem_ready` is never high while `nub_resetn`=0.

## Configuration
- `NUBUS_SRAM_REGOUT_EN` defined: an extra output register stage follows CAPTURE. `mem_ready` and `mem_rdata` appear one cycle later, at edge N+3+`WAIT_STATES`. The slave port sees no combinational path from `sram_rdata`.
- Not defined: timing exactly as above, N+2+`WAIT_STATES`.

## Test plan
- Reset: hold `nub_resetn`=0 with `mem_valid`=1 → `mem_ready`, `sram_cs`, `mem_rdata` all 0; no SRAM access after release until `mem_valid` is re-sampled in IDLE.
- Word write then read, with `ADDR_W`=12, `WAIT_STATES`=0, `mem_myslot`=1:
  - write `0x87654321` to `0xF0000000` with `mem_wstrb`=F → `sram_addr`=0, `sram_we`=F, `mem_write` pulses once;
  - read back → `mem_rdata`=`0x87654321` with `mem_ready` at edge N+2.
- Byte lane: zeroed SRAM, write `0x87654321` to `0xF0000010` with `mem_wstrb`=`0010` → `sram_addr`=4; readback = `0x00004300`.
- Wait states: `WAIT_STATES`=3, read → `mem_ready` at edge N+5, `sram_cs` high for exactly one cycle. With `NUBUS_SRAM_REGOUT_EN` defined → edge N+6.
- Held request: `mem_valid` held high for 10 cycles → exactly one `sram_cs` pulse and one `mem_ready` pulse. Drop `mem_valid` for one edge and reassert → a second access occurs.
- Not selected: `mem_valid`=1, `mem_myslot`=`mem_myexp`=0 for 8 cycles → `sram_cs`=0 and `mem_ready`=0 throughout. Setting `mem_myexp`=1 → access proceeds normally.
